memory_game_core: RTL and testbench

- Parametrised game-control core for the VGA card-matching game.
- Owns board symbol storage, cursor movement, the two-pick flip/compare sequence, the mismatch display timer, lives and pair counting, and win/lose detection.
- Replaces the fixed 6x6 state-machine, arrow-key and compare logic with one block, sized by grid dimensions.
- Feeds the draw block: cursor position, face-up/matched masks and state.

---
 rtl/memory_game_pkg.sv | 20 ++
 rtl/game_cursor.sv | 56 +++++
 rtl/memory_game_core.sv | 197 +++++++++++++++++++
 tb/tb_memory_game_core.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_game_pkg.sv
// Shared types and constants for the card-matching game core.
package memory_game_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PICK1   = 3'd1,
    S_PICK2   = 3'd2,
    S_COMPARE = 3'd3,
    S_SHOW    = 3'd4,
    S_DONE    = 3'd5
  } game_state_t;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  localparam int LIVES_W = 8;

endpackage

// File: rtl/game_cursor.sv
// Wrap-around row/column cursor with up > down > left > right key priority.
module game_cursor
  import memory_game_pkg::*;
#(
  parameter int ROWS = 6,
  parameter int COLS = 6,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [3:0]    keys_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o
);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (!en_i) begin
      row_d = row_q;
    end else if (keys_i[KEY_UP]) begin
      row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
    end else if (keys_i[KEY_DOWN]) begin
      row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    end else if (keys_i[KEY_LEFT]) begin
      col_d = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
    end else if (keys_i[KEY_RIGHT]) begin
      col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
    end else begin
      col_d = col_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/memory_game_core.sv
// Card-matching game controller: board RAM, two-pick flip/compare, lives, win/lose.
// Define MEMORY_GAME_MOVES_EN to add the saturating `moves` compare counter.
module memory_game_core
  import memory_game_pkg::*;
#(
  parameter int ROWS        = 6,
  parameter int COLS        = 6,
  parameter int SYM_W       = 5,
  parameter int SHOW_CYCLES = 50000000,
  parameter int MAX_LIVES   = 8,
  localparam int N  = ROWS * COLS,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int PW = $clog2(N / 2 + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         keys,
  input  logic               select,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [SYM_W-1:0]   wr_sym,
  output logic [RW-1:0]      cursor_row,
  output logic [CW-1:0]      cursor_col,
  output logic [N-1:0]       face_up,
  output logic [N-1:0]       matched,
  output logic [2:0]         state_out,
  output logic [PW-1:0]      pairs_found,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               game_won
`ifdef MEMORY_GAME_MOVES_EN
  ,output logic [15:0]       moves
`endif
);

  localparam int TW = $clog2(SHOW_CYCLES);

  game_state_t        state_q, state_d;
  logic [SYM_W-1:0]   board_q [N];
  logic [N-1:0]       face_q, face_d, matched_q, matched_d;
  logic [PW-1:0]      pairs_q, pairs_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [AW-1:0]      idx1_q, idx1_d, idx2_q, idx2_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               over_q, won_q;
  logic [AW-1:0]      cur_idx_s;
  logic               sel_ok_s, sym_eq_s, last_pair_s, start_game_s, move_en_s;

  assign start_game_s = start && (state_q == S_IDLE);
  assign move_en_s    = (state_q == S_PICK1) || (state_q == S_PICK2);
  assign cur_idx_s    = AW'(32'(cursor_row) * 32'(COLS) + 32'(cursor_col));
  // The first pick is already face-up, so this also rejects re-picking it.
  assign sel_ok_s     = select && !face_q[cur_idx_s] && !matched_q[cur_idx_s];
  assign sym_eq_s     = (board_q[idx1_q] == board_q[idx2_q]);
  assign last_pair_s  = ((pairs_q + PW'(1)) == PW'(N / 2));

  game_cursor #(.ROWS(ROWS), .COLS(COLS)) u_cursor (
    .clk_i  (clock),
    .rst_i  (reset),
    .clr_i  (start_game_s),
    .en_i   (move_en_s),
    .keys_i (keys),
    .row_o  (cursor_row),
    .col_o  (cursor_col)
  );

  always_ff @(posedge clock) begin
    if (wr_en && (state_q == S_IDLE) && (32'(wr_addr) < N)) begin
      board_q[wr_addr] <= wr_sym;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = start ? S_PICK1 : S_IDLE;
      S_PICK1:   state_d = sel_ok_s ? S_PICK2 : S_PICK1;
      S_PICK2:   state_d = sel_ok_s ? S_COMPARE : S_PICK2;
      S_COMPARE: begin
        if (!sym_eq_s)        state_d = S_SHOW;
        else if (last_pair_s) state_d = S_DONE;
        else                  state_d = S_PICK1;
      end
      S_SHOW: begin
        if (timer_q != '0)       state_d = S_SHOW;
        else if (lives_q == '0)  state_d = S_DONE;
        else                     state_d = S_PICK1;
      end
      S_DONE:    state_d = start ? S_IDLE : S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    face_d    = face_q;
    matched_d = matched_q;
    pairs_d   = pairs_q;
    lives_d   = lives_q;
    idx1_d    = idx1_q;
    idx2_d    = idx2_q;
    timer_d   = timer_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          face_d    = '0;
          matched_d = '0;
          pairs_d   = '0;
          lives_d   = LIVES_W'(MAX_LIVES);
        end else begin
          lives_d   = lives_q;
        end
      end
      S_PICK1, S_PICK2: begin
        if (sel_ok_s) begin
          face_d[cur_idx_s] = 1'b1;
          if (state_q == S_PICK1) idx1_d = cur_idx_s;
          else                    idx2_d = cur_idx_s;
        end else begin
          face_d = face_q;
        end
      end
      S_COMPARE: begin
        if (sym_eq_s) begin
          matched_d[idx1_q] = 1'b1;
          matched_d[idx2_q] = 1'b1;
          pairs_d           = pairs_q + PW'(1);
        end else begin
          lives_d = lives_q - LIVES_W'(1);
          timer_d = TW'(SHOW_CYCLES - 1);
        end
      end
      S_SHOW: begin
        if (timer_q == '0) begin
          face_d[idx1_q] = 1'b0;
          face_d[idx2_q] = 1'b0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: face_d = face_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      face_q    <= '0;
      matched_q <= '0;
      pairs_q   <= '0;
      lives_q   <= LIVES_W'(MAX_LIVES);
      idx1_q    <= '0;
      idx2_q    <= '0;
      timer_q   <= '0;
      over_q    <= 1'b0;
      won_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      face_q    <= face_d;
      matched_q <= matched_d;
      pairs_q   <= pairs_d;
      lives_q   <= lives_d;
      idx1_q    <= idx1_d;
      idx2_q    <= idx2_d;
      timer_q   <= timer_d;
      over_q    <= (state_d == S_DONE);
      won_q     <= (state_d == S_DONE) && (pairs_d == PW'(N / 2));
    end
  end

  assign state_out   = state_q;
  assign face_up     = face_q;
  assign matched     = matched_q;
  assign pairs_found = pairs_q;
  assign lives       = lives_q;
  assign game_over   = over_q;
  assign game_won    = won_q;

`ifdef MEMORY_GAME_MOVES_EN
  logic [15:0] moves_q;

  always_ff @(posedge clock) begin
    if (reset || start_game_s) begin
      moves_q <= 16'd0;
    end else if ((state_d == S_COMPARE) && (state_q != S_COMPARE) && (moves_q != 16'hFFFF)) begin
      moves_q <= moves_q + 16'd1;
    end else begin
      moves_q <= moves_q;
    end
  end

  assign moves = moves_q;
`endif

endmodule

// File: tb/tb_memory_game_core.sv
// Directed scoreboard bench for memory_game_core on a 2x2 board A,B,A,B.
module tb_memory_game_core;

  localparam logic [4:0] SYM_A = 5'd10;
  localparam logic [4:0] SYM_B = 5'd11;

  logic       clock, reset, start, select, wr_en;
  logic [3:0] keys;
  logic [1:0] wr_addr;
  logic [4:0] wr_sym;
  logic [0:0] cursor_row, cursor_col;
  logic [3:0] face_up, matched;
  logic [2:0] state_out;
  logic [1:0] pairs_found;
  logic [7:0] lives;
  logic       game_over, game_won;
`ifdef MEMORY_GAME_MOVES_EN
  logic [15:0] moves;
`endif

  memory_game_core #(
    .ROWS(2), .COLS(2), .SYM_W(5), .SHOW_CYCLES(4), .MAX_LIVES(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .keys        (keys),
    .select      (select),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_sym      (wr_sym),
    .cursor_row  (cursor_row),
    .cursor_col  (cursor_col),
    .face_up     (face_up),
    .matched     (matched),
    .state_out   (state_out),
    .pairs_found (pairs_found),
    .lives       (lives),
    .game_over   (game_over),
    .game_won    (game_won)
`ifdef MEMORY_GAME_MOVES_EN
    ,.moves      (moves)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic [3:0] fu;
    logic [3:0] ma;
    logic [1:0] pr;
    logic [7:0] lv;
    logic       won;
    logic       r;
    logic       c;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_front();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      t = tags.pop_front();
      cmp({t, ".state"},   32'(state_out),   32'(e.st));
      cmp({t, ".face_up"}, 32'(face_up),     32'(e.fu));
      cmp({t, ".matched"}, 32'(matched),     32'(e.ma));
      cmp({t, ".pairs"},   32'(pairs_found), 32'(e.pr));
      cmp({t, ".lives"},   32'(lives),       32'(e.lv));
      cmp({t, ".over"},    32'(game_over),   32'(e.st == 3'd5));
      cmp({t, ".won"},     32'(game_won),    32'(e.won));
      cmp({t, ".row"},     32'(cursor_row),  32'(e.r));
      cmp({t, ".col"},     32'(cursor_col),  32'(e.c));
    end
  endtask

  task automatic push_exp(input string tag, input logic [2:0] st, input logic [3:0] fu,
                          input logic [3:0] ma, input logic [1:0] pr, input logic [7:0] lv,
                          input logic won, input logic r, input logic c);
    exp_t e;
    e.st = st; e.fu = fu; e.ma = ma; e.pr = pr; e.lv = lv; e.won = won; e.r = r; e.c = c;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  // Drive one cycle of stimulus, queue the expected outcome, compare after the edge.
  task automatic step(input string tag, input logic s, input logic [3:0] k, input logic sel,
                      input logic [2:0] st, input logic [3:0] fu, input logic [3:0] ma,
                      input logic [1:0] pr, input logic [7:0] lv, input logic won,
                      input logic r, input logic c);
    push_exp(tag, st, fu, ma, pr, lv, won, r, c);
    start = s; keys = k; select = sel;
    @(posedge clock); #1;
    start = 1'b0; keys = 4'd0; select = 1'b0;
    check_front();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; keys = 4'd0; select = 1'b0;
    wr_en = 1'b0; wr_addr = 2'd0; wr_sym = 5'd0;
    repeat (2) @(posedge clock);
    #1;
    push_exp("reset", 3'd0, 4'b0000, 4'b0000, 2'd0, 8'd2, 1'b0, 1'b0, 1'b0);
    check_front();
`ifdef MEMORY_GAME_MOVES_EN
    cmp("moves_reset", 32'(moves), 32'd0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_sym = (i % 2 == 1) ? SYM_B : SYM_A;
      @(posedge clock); #1;
    end
    wr_en = 1'b0;

    // Win: pairs (0,2) then (3,1), with illegal reselects on the way.
    step("win_start",    1, 4'd0, 0, 3'd1, 4'b0000, 4'b0000, 2'd0, 8'd2, 0, 0, 0);
    step("win_sel0",     0, 4'd0, 1, 3'd2, 4'b0001, 4'b0000, 2'd0, 8'd2, 0, 0, 0);
    step("win_resel0",   0, 4'd0, 1, 3'd2, 4'b0001, 4'b0000, 2'd0, 8'd2, 0, 0, 0);
    step("win_down",     0, 4'd2, 0, 3'd2, 4'b0001, 4'b0000, 2'd0, 8'd2, 0, 1, 0);
    step("win_sel2",     0, 4'd0, 1, 3'd3, 4'b0101, 4'b0000, 2'd0, 8'd2, 0, 1, 0);
    step("win_cmp1",     0, 4'd0, 0, 3'd1, 4'b0101, 4'b0101, 2'd1, 8'd2, 0, 1, 0);
    step("win_selmatch", 0, 4'd0, 1, 3'd1, 4'b0101, 4'b0101, 2'd1, 8'd2, 0, 1, 0);
    step("win_right",    0, 4'd8, 0, 3'd1, 4'b0101, 4'b0101, 2'd1, 8'd2, 0, 1, 1);
    step("win_sel3",     0, 4'd0, 1, 3'd2, 4'b1101, 4'b0101, 2'd1, 8'd2, 0, 1, 1);
    step("win_resel3",   0, 4'd0, 1, 3'd2, 4'b1101, 4'b0101, 2'd1, 8'd2, 0, 1, 1);
    step("win_up",       0, 4'd1, 0, 3'd2, 4'b1101, 4'b0101, 2'd1, 8'd2, 0, 0, 1);
    step("win_sel1",     0, 4'd0, 1, 3'd3, 4'b1111, 4'b0101, 2'd1, 8'd2, 0, 0, 1);
    step("win_done",     0, 4'd0, 0, 3'd5, 4'b1111, 4'b1111, 2'd2, 8'd2, 1, 0, 1);
`ifdef MEMORY_GAME_MOVES_EN
    cmp("moves_win", 32'(moves), 32'd2);
`endif
    wr_en = 1'b1; wr_addr = 2'd0; wr_sym = SYM_B;
    step("done_wr",      0, 4'd0, 0, 3'd5, 4'b1111, 4'b1111, 2'd2, 8'd2, 1, 0, 1);
    wr_en = 1'b0;
    step("done_to_idle", 1, 4'd0, 0, 3'd0, 4'b1111, 4'b1111, 2'd2, 8'd2, 0, 0, 1);
    step("restart",      1, 4'd0, 0, 3'd1, 4'b0000, 4'b0000, 2'd0, 8'd2, 0, 0, 0);
`ifdef MEMORY_GAME_MOVES_EN
    cmp("moves_restart", 32'(moves), 32'd0);
`endif

    // Mismatch 0/1 (board write in DONE must not have made them equal), select+key together.
    step("mm_sel0",      0, 4'd0, 1, 3'd2, 4'b0001, 4'b0000, 2'd0, 8'd2, 0, 0, 0);
    step("mm_right",     0, 4'd8, 0, 3'd2, 4'b0001, 4'b0000, 2'd0, 8'd2, 0, 0, 1);
    step("mm_sel1_down", 0, 4'd2, 1, 3'd3, 4'b0011, 4'b0000, 2'd0, 8'd2, 0, 1, 1);
    step("mm_show1",     0, 4'd0, 0, 3'd4, 4'b0011, 4'b0000, 2'd0, 8'd1, 0, 1, 1);
    step("mm_show2",     0, 4'd4, 1, 3'd4, 4'b0011, 4'b0000, 2'd0, 8'd1, 0, 1, 1);
    step("mm_show3",     0, 4'd1, 0, 3'd4, 4'b0011, 4'b0000, 2'd0, 8'd1, 0, 1, 1);
    step("mm_show4",     0, 4'd0, 0, 3'd4, 4'b0011, 4'b0000, 2'd0, 8'd1, 0, 1, 1);
    step("mm_hide",      0, 4'd0, 0, 3'd1, 4'b0000, 4'b0000, 2'd0, 8'd1, 0, 1, 1);

    // Second mismatch 3/2 loses the game.
    step("lose_sel3",    0, 4'd0, 1, 3'd2, 4'b1000, 4'b0000, 2'd0, 8'd1, 0, 1, 1);
    step("lose_left",    0, 4'd4, 0, 3'd2, 4'b1000, 4'b0000, 2'd0, 8'd1, 0, 1, 0);
    step("lose_sel2",    0, 4'd0, 1, 3'd3, 4'b1100, 4'b0000, 2'd0, 8'd1, 0, 1, 0);
    step("lose_show1",   0, 4'd0, 0, 3'd4, 4'b1100, 4'b0000, 2'd0, 8'd0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step("lose_show",  0, 4'd0, 0, 3'd4, 4'b1100, 4'b0000, 2'd0, 8'd0, 0, 1, 0);
    end
    step("lose_done",    0, 4'd0, 0, 3'd5, 4'b0000, 4'b0000, 2'd0, 8'd0, 0, 1, 0);
`ifdef MEMORY_GAME_MOVES_EN
    cmp("moves_lose", 32'(moves), 32'd2);
`endif

    // Cursor wrap and key priority.
    step("wr_idle",      1, 4'd0, 0, 3'd0, 4'b0000, 4'b0000, 2'd0, 8'd0, 0, 1, 0);
    step("wr_start",     1, 4'd0, 0, 3'd1, 4'b0000, 4'b0000, 2'd0, 8'd2, 0, 0, 0);
    step("wrap_left",    0, 4'd4, 0, 3'd1, 4'b0000, 4'b0000, 2'd0, 8'd2, 0, 0, 1);
    step("wrap_up",      0, 4'd1, 0, 3'd1, 4'b0000, 4'b0000, 2'd0, 8'd2, 0, 1, 1);
    step("prio_up_rt",   0, 4'd9, 0, 3'd1, 4'b0000, 4'b0000, 2'd0, 8'd2, 0, 0, 1);

    // Reset in SHOW.
    step("rst_sel1",     0, 4'd0, 1, 3'd2, 4'b0010, 4'b0000, 2'd0, 8'd2, 0, 0, 1);
    step("rst_left",     0, 4'd4, 0, 3'd2, 4'b0010, 4'b0000, 2'd0, 8'd2, 0, 0, 0);
    step("rst_sel0",     0, 4'd0, 1, 3'd3, 4'b0011, 4'b0000, 2'd0, 8'd2, 0, 0, 0);
    step("rst_show",     0, 4'd0, 0, 3'd4, 4'b0011, 4'b0000, 2'd0, 8'd1, 0, 0, 0);
`ifdef MEMORY_GAME_MOVES_EN
    cmp("moves_one", 32'(moves), 32'd1);
`endif
    reset = 1'b1;
    step("rst_apply",    0, 4'd0, 0, 3'd0, 4'b0000, 4'b0000, 2'd0, 8'd2, 0, 0, 0);
    reset = 1'b0;
`ifdef MEMORY_GAME_MOVES_EN
    cmp("moves_rst", 32'(moves), 32'd0);
`endif
    step("rst_hold1",    0, 4'd0, 0, 3'd0, 4'b0000, 4'b0000, 2'd0, 8'd2, 0, 0, 0);
    step("rst_hold2",    0, 4'd2, 1, 3'd0, 4'b0000, 4'b0000, 2'd0, 8'd2, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
